// File: rtl/nrisk_pkg.sv
// Shared definitions for the nRisk 8-bit core control unit:
// opcodes, FSM state encoding, register count and decoder class bundle.
package nrisk_pkg;

   localparam int unsigned NREG = 6;

   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_LDI  = 4'h1;
   localparam logic [3:0] OP_LD   = 4'h2;
   localparam logic [3:0] OP_ST   = 4'h3;
   localparam logic [3:0] OP_ADD  = 4'h4;
   localparam logic [3:0] OP_SUB  = 4'h5;
   localparam logic [3:0] OP_AND  = 4'h6;
   localparam logic [3:0] OP_OR   = 4'h7;
   localparam logic [3:0] OP_JMP  = 4'h8;
   localparam logic [3:0] OP_BEQZ = 4'h9;
   localparam logic [3:0] OP_HLT  = 4'hF;

   typedef enum logic [1:0] {
      FETCH  = 2'd0,
      DECODE = 2'd1,
      WRITE  = 2'd2,
      HALT   = 2'd3
   } estado_t;

   // Instruction class flags produced by the decoder.
   typedef struct packed {
      logic reg_op;       // instruction names a bank register in ir[3:1]
      logic uses_imm;     // consumes the byte following the opcode
      logic writes_bank;  // ends with a bank write (LDI/ST)
      logic branch;       // JMP/BEQZ
      logic halt;         // HLT
      logic illegal;      // unassigned opcode
   } classe_t;

endpackage

// File: rtl/unidade_controle_decodificador.sv
// Combinational opcode classifier for the nRisk control unit.
module decodificador
   import nrisk_pkg::*;
(
   input  logic [3:0] op,
   output classe_t    classe
);

   // Map each opcode onto its class flags; unassigned opcodes are illegal.
   always_comb begin
      classe = '0;
      case (op)
         OP_NOP:  ;
         OP_LDI:  begin
            classe.reg_op      = 1'b1;
            classe.uses_imm    = 1'b1;
            classe.writes_bank = 1'b1;
         end
         OP_LD, OP_ADD, OP_SUB, OP_AND, OP_OR: classe.reg_op = 1'b1;
         OP_ST:   begin
            classe.reg_op      = 1'b1;
            classe.writes_bank = 1'b1;
         end
         OP_JMP, OP_BEQZ: begin
            classe.uses_imm = 1'b1;
            classe.branch   = 1'b1;
         end
         OP_HLT:  classe.halt    = 1'b1;
         default: classe.illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/unidade_controle.sv
// Multicycle control/sequencer for the nRisk 8-bit core: fetches from an
// asynchronous ROM, drives the register bank and holds acc plus the ALU.
//
// state  | meaning
// FETCH  | latch instr into ir, pc+1
// DECODE | registrador valid, bank read lands mid-cycle; execute or branch
// WRITE  | sinal high for one cycle, bank writes on the exit edge
// HALT   | stopped after HLT or error; only reset_n leaves
module unidade_controle #(
   parameter logic [7:0]  RESET_PC = 8'h00,
   parameter int unsigned NREG     = nrisk_pkg::NREG
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic [7:0] instr,
   output logic [7:0] pc,
   output logic       sinal,
   output logic [2:0] registrador,
   output logic [7:0] valorEscrita,
   input  logic [7:0] valorSaida,
   output logic [7:0] acc,
   output logic       zero,
   output logic       halted,
   output logic       erro
);
   import nrisk_pkg::*;

   estado_t    state_q, state_d;
   logic [7:0] pc_q, pc_d;
   logic [7:0] acc_q, acc_d;
   // Encoding bit 0 carries no information, so only [7:1] is kept.
   logic [7:1] ir_q, ir_d;
   logic [7:0] valor_q, valor_d;
   logic       sinal_q, sinal_d;
   logic [2:0] registrador_q, registrador_d;
   logic       halted_q, halted_d;
   logic       erro_q, erro_d;

   logic [3:0] op;
   logic [2:0] reg_idx;
   logic       reg_bad;
   logic       acc_zero;
   logic [7:0] pc_inc;
   logic [7:0] alu_res;
   classe_t    classe;

   assign op       = ir_q[7:4];
   assign reg_idx  = ir_q[3:1];
   assign reg_bad  = (32'(reg_idx) >= NREG);
   assign acc_zero = (acc_q == 8'h00);
   assign pc_inc   = pc_q + 8'd1;

   decodificador u_decodificador (
      .op     (op),
      .classe (classe)
   );

   // ALU: acc op s[r] for LD and the four arithmetic/logic ops, wrapping mod 256.
   always_comb begin
      alu_res = acc_q;
      case (op)
         OP_LD:   alu_res = valorSaida;
         OP_ADD:  alu_res = acc_q + valorSaida;
         OP_SUB:  alu_res = acc_q - valorSaida;
         OP_AND:  alu_res = acc_q & valorSaida;
         OP_OR:   alu_res = acc_q | valorSaida;
         default: alu_res = acc_q;
      endcase
   end

   // Next-state and next-output logic; outputs are computed for the state being entered.
   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      acc_d         = acc_q;
      ir_d          = ir_q;
      valor_d       = valor_q;
      sinal_d       = 1'b0;
      registrador_d = 3'b000;
      halted_d      = halted_q;
      erro_d        = erro_q;
      case (state_q)
         FETCH: begin
            ir_d          = instr[7:1];
            pc_d          = pc_inc;
            registrador_d = instr[3:1];
            state_d       = DECODE;
         end
         DECODE: begin
            if (classe.illegal || (classe.reg_op && reg_bad)) begin
               erro_d   = 1'b1;
               halted_d = 1'b1;
               state_d  = HALT;
            end else if (classe.halt) begin
               halted_d = 1'b1;
               state_d  = HALT;
            end else if (classe.writes_bank) begin
               valor_d       = classe.uses_imm ? instr : acc_q;
               pc_d          = classe.uses_imm ? pc_inc : pc_q;
               sinal_d       = 1'b1;
               registrador_d = reg_idx;
               state_d       = WRITE;
            end else if (classe.branch) begin
               pc_d    = ((op == OP_JMP) || acc_zero) ? instr : pc_inc;
               state_d = FETCH;
            end else if (classe.reg_op) begin
               acc_d   = alu_res;
               state_d = FETCH;
            end else begin
               state_d = FETCH;
            end
         end
         WRITE: begin
            state_d = FETCH;
         end
         HALT: begin
            halted_d = 1'b1;
            state_d  = HALT;
         end
         default: state_d = FETCH;
      endcase
   end

   // State and registered outputs; reset clears sinal immediately so an interrupted write never lands.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= FETCH;
         pc_q          <= RESET_PC;
         acc_q         <= 8'h00;
         ir_q          <= '0;
         valor_q       <= 8'h00;
         sinal_q       <= 1'b0;
         registrador_q <= 3'b000;
         halted_q      <= 1'b0;
         erro_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         acc_q         <= acc_d;
         ir_q          <= ir_d;
         valor_q       <= valor_d;
         sinal_q       <= sinal_d;
         registrador_q <= registrador_d;
         halted_q      <= halted_d;
         erro_q        <= erro_d;
      end
   end

   assign pc           = pc_q;
   assign acc          = acc_q;
   assign zero         = acc_zero;
   assign sinal        = sinal_q;
   assign registrador  = registrador_q;
   assign valorEscrita = valor_q;
   assign halted       = halted_q;
   assign erro         = erro_q;

endmodule
